// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage: ID/EX pipeline register with load-use hazard detection.
// A load in EX whose destination is read by the instruction in ID stalls the
// front end for one cycle while a bubble goes into EX. A flush kills the ID
// instruction and also inserts a bubble.
// Optional macro ID_EX_STALL_COUNT_EN builds a saturating 16-bit stall
// counter; without it, stall_count is tied to zero.
module id_ex_hazard_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_BITS   = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  valid_ID,
   input  logic [REG_BITS-1:0]   rs_num_ID,
   input  logic [REG_BITS-1:0]   rt_num_ID,
   input  logic [REG_BITS-1:0]   rd_num_ID,
   input  logic                  uses_rt_ID,
   input  logic [DATA_WIDTH-1:0] rs_data_ID,
   input  logic [DATA_WIDTH-1:0] rt_data_ID,
   input  logic [DATA_WIDTH-1:0] imm_ID,
   input  logic [3:0]            alu_op_ID,
   input  logic                  alu_src_ID,
   input  logic                  wr_enable_ID,
   input  logic                  mem_read_ID,
   input  logic                  mem_write_ID,
   input  logic                  flush,
   output logic                  valid_EX,
   output logic [REG_BITS-1:0]   rs_num_EX,
   output logic [REG_BITS-1:0]   rt_num_EX,
   output logic [REG_BITS-1:0]   rd_num_EX,
   output logic [DATA_WIDTH-1:0] rs_data_EX,
   output logic [DATA_WIDTH-1:0] rt_data_EX,
   output logic [DATA_WIDTH-1:0] imm_EX,
   output logic [3:0]            alu_op_EX,
   output logic                  alu_src_EX,
   output logic                  wr_enable_EX,
   output logic                  mem_read_EX,
   output logic                  mem_write_EX,
   output logic                  stall,
   output logic [15:0]           stall_count
);

   // All EX-stage state in one record so a bubble is a single '0 assignment.
   typedef struct packed {
      logic                  valid;
      logic [REG_BITS-1:0]   rs_num;
      logic [REG_BITS-1:0]   rt_num;
      logic [REG_BITS-1:0]   rd_num;
      logic [DATA_WIDTH-1:0] rs_data;
      logic [DATA_WIDTH-1:0] rt_data;
      logic [DATA_WIDTH-1:0] imm;
      logic [3:0]            alu_op;
      logic                  alu_src;
      logic                  wr_enable;
      logic                  mem_read;
      logic                  mem_write;
   } ex_regs_t;

   ex_regs_t ex_d, ex_q;
   logic     hazard;
   logic     rs_match, rt_match;

   // Load in EX produces a value that the ID instruction needs this cycle;
   // r0 is hardwired to zero and can never be a real dependency.
   always_comb begin
      rs_match = (ex_q.rd_num == rs_num_ID);
      rt_match = uses_rt_ID & (ex_q.rd_num == rt_num_ID);
      hazard   = valid_ID & ex_q.valid & ex_q.mem_read & ex_q.wr_enable &
                 (ex_q.rd_num != '0) & (rs_match | rt_match);
   end

   // A flushed ID instruction is discarded, so there is nothing to hold.
   assign stall = hazard & ~flush;

   // Next EX contents: bubble on flush or hazard, otherwise capture ID with
   // side-effecting controls qualified by valid_ID.
   always_comb begin
      ex_d = '0;
      if (!flush && !hazard) begin
         ex_d.valid     = valid_ID;
         ex_d.rs_num    = rs_num_ID;
         ex_d.rt_num    = rt_num_ID;
         ex_d.rd_num    = rd_num_ID;
         ex_d.rs_data   = rs_data_ID;
         ex_d.rt_data   = rt_data_ID;
         ex_d.imm       = imm_ID;
         ex_d.alu_op    = alu_op_ID;
         ex_d.alu_src   = alu_src_ID;
         ex_d.wr_enable = wr_enable_ID & valid_ID;
         ex_d.mem_read  = mem_read_ID  & valid_ID;
         ex_d.mem_write = mem_write_ID & valid_ID;
      end
   end

   // ID/EX pipeline register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ex_q <= '0;
      else       ex_q <= ex_d;
   end

   assign valid_EX     = ex_q.valid;
   assign rs_num_EX    = ex_q.rs_num;
   assign rt_num_EX    = ex_q.rt_num;
   assign rd_num_EX    = ex_q.rd_num;
   assign rs_data_EX   = ex_q.rs_data;
   assign rt_data_EX   = ex_q.rt_data;
   assign imm_EX       = ex_q.imm;
   assign alu_op_EX    = ex_q.alu_op;
   assign alu_src_EX   = ex_q.alu_src;
   assign wr_enable_EX = ex_q.wr_enable;
   assign mem_read_EX  = ex_q.mem_read;
   assign mem_write_EX = ex_q.mem_write;

`ifdef ID_EX_STALL_COUNT_EN
   logic [15:0] stall_count_d, stall_count_q;

   // Count stall cycles, holding at all-ones rather than wrapping.
   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && (stall_count_q != 16'hFFFF))
         stall_count_d = stall_count_q + 16'd1;
   end

   // Stall counter register, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) stall_count_q <= '0;
      else       stall_count_q <= stall_count_d;
   end

   assign stall_count = stall_count_q;
`else
   assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage: load-use stalls, r0, rt gating,
// flush priority, pass-through data, back-to-back loads, async reset.
module tb_id_ex_hazard_stage;
   logic        clk = 1'b0;
   logic        reset;
   logic        valid_ID;
   logic [4:0]  rs_num_ID, rt_num_ID, rd_num_ID;
   logic        uses_rt_ID;
   logic [31:0] rs_data_ID, rt_data_ID, imm_ID;
   logic [3:0]  alu_op_ID;
   logic        alu_src_ID, wr_enable_ID, mem_read_ID, mem_write_ID, flush;
   logic        valid_EX;
   logic [4:0]  rs_num_EX, rt_num_EX, rd_num_EX;
   logic [31:0] rs_data_EX, rt_data_EX, imm_EX;
   logic [3:0]  alu_op_EX;
   logic        alu_src_EX, wr_enable_EX, mem_read_EX, mem_write_EX;
   logic        stall;
   logic [15:0] stall_count;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   id_ex_hazard_stage #(.DATA_WIDTH(32), .REG_BITS(5)) dut (
      .clk(clk), .reset(reset), .valid_ID(valid_ID),
      .rs_num_ID(rs_num_ID), .rt_num_ID(rt_num_ID), .rd_num_ID(rd_num_ID),
      .uses_rt_ID(uses_rt_ID), .rs_data_ID(rs_data_ID), .rt_data_ID(rt_data_ID),
      .imm_ID(imm_ID), .alu_op_ID(alu_op_ID), .alu_src_ID(alu_src_ID),
      .wr_enable_ID(wr_enable_ID), .mem_read_ID(mem_read_ID),
      .mem_write_ID(mem_write_ID), .flush(flush),
      .valid_EX(valid_EX), .rs_num_EX(rs_num_EX), .rt_num_EX(rt_num_EX),
      .rd_num_EX(rd_num_EX), .rs_data_EX(rs_data_EX), .rt_data_EX(rt_data_EX),
      .imm_EX(imm_EX), .alu_op_EX(alu_op_EX), .alu_src_EX(alu_src_EX),
      .wr_enable_EX(wr_enable_EX), .mem_read_EX(mem_read_EX),
      .mem_write_EX(mem_write_EX), .stall(stall), .stall_count(stall_count)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present a decoded instruction in ID; data fields default to zero.
   task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic urt, input logic we,
                        input logic mr, input logic mw);
      valid_ID = v; rs_num_ID = rs; rt_num_ID = rt; rd_num_ID = rd;
      uses_rt_ID = urt; wr_enable_ID = we; mem_read_ID = mr; mem_write_ID = mw;
      rs_data_ID = '0; rt_data_ID = '0; imm_ID = '0; alu_op_ID = '0; alu_src_ID = 1'b0;
      #1;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #12;
      chk("rst_valid", valid_EX, 0);
      chk("rst_rd", rd_num_EX, 0);
      chk("rst_memrd", mem_read_EX, 0);
      chk("rst_stall", stall, 0);
      chk("rst_cnt", stall_count, 0);
      @(negedge clk); reset = 1'b0;

      // lw r5 then add r8,r5,r6: one stall, bubble, then add
      drive(1'b1, 5'd1, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      chk("lw5_memrd", mem_read_EX, 1);
      chk("lw5_rd", rd_num_EX, 5);
      drive(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("lu_stall", stall, 1);
      tick();
      chk("lu_bub_valid", valid_EX, 0);
      chk("lu_bub_we", wr_enable_EX, 0);
      chk("lu_bub_stall", stall, 0);
      tick();
      chk("lu_add_valid", valid_EX, 1);
      chk("lu_add_rs", rs_num_EX, 5);
      chk("lu_add_rd", rd_num_EX, 8);
      chk("lu_add_stall", stall, 0);

      // lw r7 then addi rs=3, rt=7 not a source: no stall
      drive(1'b1, 5'd2, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd3, 5'd7, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("addi_stall", stall, 0);
      tick();
      chk("addi_valid", valid_EX, 1);
      chk("addi_rs", rs_num_EX, 3);

      // lw r0 then rs=0, rt=0: never a hazard
      drive(1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("r0_stall", stall, 0);
      tick();
      chk("r0_valid", valid_EX, 1);
      chk("r0_rd", rd_num_EX, 9);

      // lw r9 then store reading r9 through rt: stall
      drive(1'b1, 5'd1, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd1, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("rt_stall", stall, 1);
      tick();
      chk("rt_bub_valid", valid_EX, 0);
      tick();
      chk("rt_sw_memwr", mem_write_EX, 1);

      // hazard together with flush: no stall, bubble
      drive(1'b1, 5'd1, 5'd10, 5'd10, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd10, 5'd2, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0);
      rs_data_ID = 32'h1111_2222; imm_ID = 32'h0000_0040;
      flush = 1'b1; #1;
      chk("fl_stall", stall, 0);
      tick();
      flush = 1'b0;
      chk("fl_valid", valid_EX, 0);
      chk("fl_rs", rs_num_EX, 0);
      chk("fl_rsdata", rs_data_EX, 0);
      chk("fl_imm", imm_EX, 0);
      chk("fl_we", wr_enable_EX, 0);

      // independent instruction: all fields pass through in one cycle
      drive(1'b1, 5'd11, 5'd12, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0);
      rs_data_ID = 32'hDEADBEEF; rt_data_ID = 32'h1234_5678;
      imm_ID = 32'hFFFFFFFC; alu_op_ID = 4'h2; alu_src_ID = 1'b1;
      tick();
      chk("pt_rsdata", rs_data_EX, 32'hDEADBEEF);
      chk("pt_rtdata", rt_data_EX, 32'h1234_5678);
      chk("pt_imm", imm_EX, 32'hFFFFFFFC);
      chk("pt_aluop", alu_op_EX, 4'h2);
      chk("pt_alusrc", alu_src_EX, 1);
      chk("pt_rt", rt_num_EX, 12);

      // invalid ID: controls gated off
      drive(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1);
      tick();
      chk("inv_valid", valid_EX, 0);
      chk("inv_we", wr_enable_EX, 0);
      chk("inv_memrd", mem_read_EX, 0);
      chk("inv_memwr", mem_write_EX, 0);

      // back-to-back dependent loads: one stall, second load proceeds
      drive(1'b1, 5'd1, 5'd14, 5'd14, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd14, 5'd15, 5'd15, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("bb_stall", stall, 1);
      tick();
      chk("bb_bub", valid_EX, 0);
      tick();
      chk("bb_lw2_memrd", mem_read_EX, 1);
      chk("bb_lw2_rd", rd_num_EX, 15);

`ifdef ID_EX_STALL_COUNT_EN
      chk("cnt", stall_count, 3);
`else
      chk("cnt", stall_count, 0);
`endif

      // reset between edges during a stall
      drive(1'b1, 5'd15, 5'd0, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("mr_stall_pre", stall, 1);
      #2 reset = 1'b1; #1;
      chk("mr_stall", stall, 0);
      chk("mr_valid", valid_EX, 0);
      chk("mr_memrd", mem_read_EX, 0);
      chk("mr_rd", rd_num_EX, 0);
      chk("mr_cnt", stall_count, 0);
      @(negedge clk); reset = 1'b0;
      tick();
      chk("post_rst_valid", valid_EX, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register plus load-use hazard detector. It sits directly upstream of the EX-stage forwarding unit and supplies its rs_num_EX, rt_num_EX and operand data.
- Latches decoded ID fields each cycle and drives stall to the PC and IF/ID registers on a load-use hazard.
- Inserts a one-cycle bubble into EX on a load-use hazard or on a flush.

Parameters:
- DATA_WIDTH, 32, width of register data and immediate.
- REG_BITS, 5, width of register numbers.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_ID  input  1  ID holds a real instruction.
- rs_num_ID  input  REG_BITS  source register 1 number.
- rt_num_ID  input  REG_BITS  source register 2 number.
- rd_num_ID  input  REG_BITS  destination register number.
- uses_rt_ID  input  1  instruction reads rt as a source (R-type, store, branch).
- rs_data_ID  input  DATA_WIDTH  register file read data 1.
- rt_data_ID  input  DATA_WIDTH  register file read data 2.
- imm_ID  input  DATA_WIDTH  sign-extended immediate.
- alu_op_ID  input  4  ALU operation code.
- alu_src_ID  input  1  1 = immediate is ALU input 2.
- wr_enable_ID  input  1  writes the register file.
- mem_read_ID  input  1  load.
- mem_write_ID  input  1  store.
- flush  input  1  taken branch/jump resolved in EX; kill the ID instruction.
- valid_EX, rs_num_EX, rt_num_EX, rd_num_EX, rs_data_EX, rt_data_EX, imm_EX, alu_op_EX, alu_src_EX, wr_enable_EX, mem_read_EX, mem_write_EX  output  same widths as the ID inputs  registered EX copies.
- stall  output  1  hold PC and IF/ID this cycle.
- stall_count  output  16  count of stall cycles (see Optional Feature).

Behaviour:
- Reset (async, active-high): every _EX output = 0 and stall_count = 0. stall is combinational and evaluates to 0 because mem_read_EX = 0.
- Hazard (combinational, same cycle): hazard = valid_ID & valid_EX & mem_read_EX & wr_enable_EX & (rd_num_EX != 0) & ((rd_num_EX == rs_num_ID) | (uses_rt_ID & rd_num_EX == rt_num_ID)).
- stall = hazard & ~flush.
- Register update each rising clk, priority order:
  1. flush = 1: load a bubble (all _EX outputs 0). Flush overrides hazard, since the ID instruction is being discarded.
  2. hazard = 1: load a bubble. The ID instruction is held upstream by stall and re-presented next cycle.
  3. Otherwise: load all ID fields. valid_EX = valid_ID. Control bits are ANDed with valid_ID, so valid_ID = 0 produces a bubble.
- Latency: one cycle from ID inputs to _EX outputs.
- A load-use stall lasts exactly one cycle. After the bubble, mem_read_EX = 0, so the hazard clears. The forwarding unit then covers the distance-2 dependency from the WB stage.
- Register 0 never causes a stall.
- Back-to-back loads where the second load depends on the first produce one stall; the second load then proceeds.
- Reset asserted mid-stall: outputs clear immediately, and stall drops in the same cycle.

Optional Feature:
- Macro: ID_EX_STALL_COUNT_EN.
- Defined: stall_count increments on every rising clk where stall = 1. It saturates at 16'hFFFF and is cleared only by reset.
- Undefined: no counter logic is built, and stall_count is tied to 0.

Test Plan:
- lw r5 in EX (mem_read_EX = 1, wr_enable_EX = 1, rd_num_EX = 5), ID = add rs = 5, rt = 6, uses_rt = 1 -> stall = 1 for one cycle. Next cycle valid_EX = 0 and wr_enable_EX = 0, then the add appears in EX with rs_num_EX = 5 and stall = 0.
- lw r7 in EX, ID = addi rs = 3, rt = 7, uses_rt_ID = 0 -> stall = 0. The addi enters EX on the next edge.
- lw r0 in EX, ID rs = 0 -> stall = 0, no bubble.
- Hazard condition true with flush = 1 on the same cycle -> stall = 0, and the next EX is a bubble (all outputs 0).
- Independent stream: rs_data_ID = 32'hDEADBEEF, imm_ID = 32'hFFFFFFFC, alu_op_ID = 4'h2 -> identical values on the _EX outputs one cycle later.
- With ID_EX_STALL_COUNT_EN defined, three separate load-use hazards -> stall_count = 3. Reset asserted between edges -> all outputs 0 immediately, with no wait for a clock edge.
